// File: rtl/cascade_lake_sched.sv
// cascade_lake_sched
//   Frame scheduler for the cascaded 3x3 stencil pipeline. On an accepted
//   start it strobes in_input_read_valid for W*H cycles in raster order and
//   tracks col/row. It raises out_output_write_en only for pixels whose full
//   cascaded stencil window is valid. It then drains the pipeline latency and
//   pulses done.
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   start, cfg_w, cfg_h : frame request and size (sampled in IDLE only)
//   busy, cfg_err       : frame in flight / rejected-config pulse
//   in_input_read_valid : pixel consumed from source this cycle
//   col, row            : coordinates of the pixel read this cycle
//   out_output_write_en : pipeline output carries a valid result
//   done, frame_cnt     : frame-complete pulse, completed-frame counter
module cascade_lake_sched #(
   parameter int KW       = 3,
   parameter int NSTAGE   = 2,
   parameter int PIPE_LAT = 1,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [CW-1:0] cfg_w,
   input  logic [CW-1:0] cfg_h,
   output logic          busy,
   output logic          cfg_err,
   output logic          in_input_read_valid,
   output logic [CW-1:0] col,
   output logic [CW-1:0] row,
   output logic          out_output_write_en,
   output logic          done,
   output logic [CW-1:0] frame_cnt
);
   localparam int MARGIN = NSTAGE * (KW - 1);
   localparam int DW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [CW-1:0] MARG = CW'(MARGIN);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       w_q, w_d, h_q, h_d;
   logic [CW-1:0]       col_q, col_d, row_q, row_d, fcnt_q, fcnt_d;
   logic                busy_q, busy_d, err_q, err_d, rv_q, rv_d, done_q, done_d;
   logic [DW-1:0]       dcnt_q, dcnt_d;
   logic [PIPE_LAT-1:0] vld_pipe_q, vld_pipe_d;
   logic                region;
   logic                last_col, last_px;

   // Region bit is formed from the registered read coordinates, so the
   // delay line output lines up with the pipeline output PIPE_LAT later.
   assign region   = rv_q && (col_q >= MARG) && (row_q >= MARG);
   assign last_col = (col_q == w_q - CW'(1));
   assign last_px  = last_col && (row_q == h_q - CW'(1));

   always_comb begin
      state_d    = state_q;
      w_d        = w_q;
      h_d        = h_q;
      col_d      = col_q;
      row_d      = row_q;
      fcnt_d     = fcnt_q;
      busy_d     = busy_q;
      dcnt_d     = dcnt_q;
      err_d      = 1'b0;
      rv_d       = 1'b0;
      done_d     = 1'b0;
      vld_pipe_d = vld_pipe_q;
      vld_pipe_d[0] = region;
      for (int i = 1; i < PIPE_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];

      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_w > MARG && cfg_h > MARG) begin
                  w_d     = cfg_w;
                  h_d     = cfg_h;
                  col_d   = '0;
                  row_d   = '0;
                  rv_d    = 1'b1;
                  busy_d  = 1'b1;
                  state_d = STREAM;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         STREAM: begin
            // End of frame comes from the terminal col/row pair; the area
            // W*H is never formed.
            if (last_px) begin
               dcnt_d  = '0;
               state_d = DRAIN;
            end else begin
               rv_d = 1'b1;
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + CW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         DRAIN: begin
            if (dcnt_q == DW'(PIPE_LAT - 1)) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               fcnt_d  = fcnt_q + CW'(1);
               state_d = IDLE;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         w_q        <= '0;
         h_q        <= '0;
         col_q      <= '0;
         row_q      <= '0;
         fcnt_q     <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         rv_q       <= 1'b0;
         done_q     <= 1'b0;
         dcnt_q     <= '0;
         vld_pipe_q <= '0;
      end else begin
         state_q    <= state_d;
         w_q        <= w_d;
         h_q        <= h_d;
         col_q      <= col_d;
         row_q      <= row_d;
         fcnt_q     <= fcnt_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         rv_q       <= rv_d;
         done_q     <= done_d;
         dcnt_q     <= dcnt_d;
         vld_pipe_q <= vld_pipe_d;
      end
   end

   assign busy                = busy_q;
   assign cfg_err             = err_q;
   assign in_input_read_valid = rv_q;
   assign col                 = col_q;
   assign row                 = row_q;
   assign out_output_write_en = vld_pipe_q[PIPE_LAT-1];
   assign done                = done_q;
   assign frame_cnt           = fcnt_q;
endmodule

// File: tb/tb_cascade_lake_sched.sv
// Directed bench for cascade_lake_sched: one instance with PIPE_LAT=1 and one
// with PIPE_LAT=3, sharing clock, reset and config. The stimulus process also
// samples both instances on the falling edge. Event cycles are counted
// relative to the cycle in which start was raised (cycle 0).
module tb_cascade_lake_sched;
   localparam int CW = 16;

   logic          clk, reset, start1, start3;
   logic [CW-1:0] cfg_w, cfg_h;
   logic          busy1, err1, rv1, we1, done1;
   logic [CW-1:0] col1, row1, fc1;
   logic          busy3, err3, rv3, we3, done3;
   logic [CW-1:0] col3, row3, fc3;

   cascade_lake_sched #(.PIPE_LAT(1), .CW(CW)) u_dut (
      .clk(clk), .reset(reset), .start(start1), .cfg_w(cfg_w), .cfg_h(cfg_h),
      .busy(busy1), .cfg_err(err1), .in_input_read_valid(rv1), .col(col1), .row(row1),
      .out_output_write_en(we1), .done(done1), .frame_cnt(fc1));

   cascade_lake_sched #(.PIPE_LAT(3), .CW(CW)) u_dut3 (
      .clk(clk), .reset(reset), .start(start3), .cfg_w(cfg_w), .cfg_h(cfg_h),
      .busy(busy3), .cfg_err(err3), .in_input_read_valid(rv3), .col(col3), .row(row3),
      .out_output_write_en(we3), .done(done3), .frame_cnt(fc3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0, bad = 0;
   int cyc = 0, t0 = 0;
   int rv_n[2], we_n[2], first_we[2], last_we[2], first_rv[2], last_rv[2];
   int done_n[2], busy_n[2], err_n[2];
   int done_hist[2][4];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      for (int d = 0; d < 2; d++) begin
         rv_n[d] = 0; we_n[d] = 0; done_n[d] = 0; busy_n[d] = 0; err_n[d] = 0;
         first_we[d] = -1; last_we[d] = -1; first_rv[d] = -1; last_rv[d] = -1;
         for (int k = 0; k < 4; k++) done_hist[d][k] = -1;
      end
   endtask

   task automatic samp(input int d, input logic rv, input logic we, input logic dn,
                       input logic bs, input logic er);
      int rel;
      rel = cyc - t0;
      if (rv) begin
         rv_n[d]++;
         if (first_rv[d] < 0) first_rv[d] = rel;
         last_rv[d] = rel;
      end
      if (we) begin
         we_n[d]++;
         if (first_we[d] < 0) first_we[d] = rel;
         last_we[d] = rel;
      end
      if (dn) begin
         if (done_n[d] < 4) done_hist[d][done_n[d]] = rel;
         done_n[d]++;
      end
      if (bs) busy_n[d]++;
      if (er) err_n[d]++;
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      samp(0, rv1, we1, done1, busy1, err1);
      samp(1, rv3, we3, done3, busy3, err3);
   endtask

   task automatic run_to(input int rel);
      while (cyc - t0 < rel) tick();
   endtask

   task automatic wait_done(input int d, input int n, input int budget);
      int k;
      k = 0;
      while (done_n[d] < n && k < budget) begin
         tick();
         k++;
      end
      if (done_n[d] < n) chk("done_timeout", done_n[d], n);
   endtask

   task automatic go1(input int w, input int h);
      clr();
      cfg_w = CW'(w);
      cfg_h = CW'(h);
      t0 = cyc;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start1 = 1'b0; start3 = 1'b0; cfg_w = '0; cfg_h = '0;
      clr();
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_outs", {busy1, err1, rv1, we1, done1}, 5'b0);
      chk("rst_colrow", {col1, row1}, 32'd0);
      chk("rst_fcnt", fc1, 0);
      chk("rst_outs3", {busy3, err3, rv3, we3, done3, fc3}, 0);

      // reset mid-frame at read index 30 (row 3, col 6, cycle 31)
      go1(8, 6);
      run_to(31);
      chk("mid_rv", rv1, 1);
      chk("mid_colrow", {col1, row1}, {16'd6, 16'd3});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_outs", {busy1, err1, rv1, we1, done1}, 5'b0);
      chk("abort_colrow_fc", {col1, row1, fc1}, 0);
      repeat (30) tick();
      chk("abort_we", we_n[0], 0);
      chk("abort_done", done_n[0], 0);
      chk("abort_fcnt", fc1, 0);

      // clean 8x6 frame
      go1(8, 6);
      wait_done(0, 1, 100);
      repeat (3) tick();
      chk("f86_rv_n", rv_n[0], 48);
      chk("f86_rv_first", first_rv[0], 1);
      chk("f86_rv_last", last_rv[0], 48);
      chk("f86_we_n", we_n[0], 8);
      chk("f86_we_first", first_we[0], 38);
      chk("f86_we_last", last_we[0], 49);
      chk("f86_done", done_hist[0][0], 50);
      chk("f86_done_n", done_n[0], 1);
      chk("f86_busy_n", busy_n[0], 49);
      chk("f86_fcnt", fc1, 1);
      chk("f86_hold", {col1, row1}, {16'd7, 16'd5});

      // bad config rejected, then minimal 5x5 frame
      go1(4, 10);
      chk("err_pulse", err1, 1);
      repeat (5) tick();
      chk("err_n", err_n[0], 1);
      chk("err_rv_n", rv_n[0], 0);
      chk("err_busy_n", busy_n[0], 0);
      go1(5, 5);
      wait_done(0, 1, 100);
      chk("f55_rv_n", rv_n[0], 25);
      chk("f55_we_n", we_n[0], 1);
      chk("f55_we_cyc", first_we[0], 26);
      chk("f55_done", done_hist[0][0], 27);
      chk("f55_fcnt", fc1, 2);

      // start held high: back-to-back 5x5 frames
      clr();
      cfg_w = 16'd5; cfg_h = 16'd5;
      t0 = cyc;
      start1 = 1'b1;
      wait_done(0, 3, 300);
      start1 = 1'b0;
      repeat (4) tick();
      chk("b2b_done0", done_hist[0][0], 27);
      chk("b2b_done1", done_hist[0][1], 54);
      chk("b2b_done2", done_hist[0][2], 81);
      chk("b2b_rv_n", rv_n[0], 75);
      chk("b2b_we_n", we_n[0], 3);
      chk("b2b_fcnt", fc1, 5);

      // start pulses during STREAM and DRAIN, cfg changed mid-frame
      go1(8, 6);
      cfg_w = 16'd5; cfg_h = 16'd5;
      run_to(10);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      run_to(49);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      repeat (10) tick();
      chk("ign_rv_n", rv_n[0], 48);
      chk("ign_we_n", we_n[0], 8);
      chk("ign_done", done_hist[0][0], 50);
      chk("ign_done_n", done_n[0], 1);
      chk("ign_fcnt", fc1, 6);

      // PIPE_LAT=3, 6x6
      clr();
      cfg_w = 16'd6; cfg_h = 16'd6;
      t0 = cyc;
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      wait_done(1, 1, 100);
      repeat (3) tick();
      chk("p3_rv_n", rv_n[1], 36);
      chk("p3_we_n", we_n[1], 4);
      chk("p3_we_first", first_we[1], 32);
      chk("p3_we_last", last_we[1], 39);
      chk("p3_done", done_hist[1][0], 40);
      chk("p3_fcnt", fc3, 1);
      chk("p3_other_idle", rv_n[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
